// File: rtl/gc_eval_engine.sv
// Half-gate garbled-circuit evaluator: two unrolled fixed-key AES-128 pipelines plus aligned delay lines.
// Define GC_EVAL_STATS_EN to add the gate_count_o completed-gate counter.
module gc_eval_engine #(
  parameter int S      = 20,
  parameter int K      = 128,
  parameter int NR_AES = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [128*(NR_AES+1)-1:0] aes_expanded_key_i,
  input  logic                      in_valid_i,
  input  logic                      is_xor_i,
  input  logic [S-1:0]              cid_i,
  input  logic [S-1:0]              gid_i,
  input  logic [K-1:0]              in0_label_i,
  input  logic [K-1:0]              in1_label_i,
  input  logic [K-1:0]              t0_i,
  input  logic [K-1:0]              t1_i,
  output logic                      out_valid_o,
  output logic [K-1:0]              out_label_o,
  output logic [S-1:0]              out_cid_o,
  output logic [S-1:0]              out_gid_o,
  output logic                      busy_o
`ifdef GC_EVAL_STATS_EN
  ,
  output logic [31:0]               gate_count_o
`endif
);

  localparam int T = NR_AES - 1;

  // Byte 0x00 sits in the top eight bits; round key i is aes_expanded_key_i[128*i +: 128].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   h [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) h[4*c+r] = b[4*((c+r)%4)+r];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = h[4*c];
      a1 = h[4*c+1];
      a2 = h[4*c+2];
      a3 = h[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ rk;
  endfunction

  function automatic logic [K-1:0] tweak(input logic [S-1:0] c, input logic [S-1:0] g,
                                         input logic lsb);
    return {{(K/2-S){1'b0}}, c, {(K/2-S-1){1'b0}}, g, lsb};
  endfunction

  logic [K-1:0]      h0_q [NR_AES];
  logic [K-1:0]      h1_q [NR_AES];
  logic [K-1:0]      wa_q [NR_AES];
  logic [K-1:0]      wb_q [NR_AES];
  logic [K-1:0]      t0_q [NR_AES];
  logic [K-1:0]      t1_q [NR_AES];
  logic [S-1:0]      cid_q [NR_AES];
  logic [S-1:0]      gid_q [NR_AES];
  logic [NR_AES-1:0] xor_q, vld_q;
  logic              out_valid_q;
  logic [K-1:0]      out_label_q, out_label_d;
  logic [S-1:0]      out_cid_q, out_gid_q;
  logic [K-1:0]      x0_in, x1_in, x0_t, x1_t, wg, we;

  assign x0_in = in0_label_i ^ tweak(cid_i, gid_i, 1'b0);
  assign x1_in = in1_label_i ^ tweak(cid_i, gid_i, 1'b1);

  // h*_q already holds x ^ AES(x) form once the tail re-applies x, so only AES output is piped.
  always_comb begin
    x0_t        = wa_q[T] ^ tweak(cid_q[T], gid_q[T], 1'b0);
    x1_t        = wb_q[T] ^ tweak(cid_q[T], gid_q[T], 1'b1);
    wg          = x0_t ^ h0_q[T] ^ (wa_q[T][0] ? t0_q[T] : '0);
    we          = x1_t ^ h1_q[T] ^ (wb_q[T][0] ? (t1_q[T] ^ wa_q[T]) : '0);
    out_label_d = xor_q[T] ? (wa_q[T] ^ wb_q[T]) : (wg ^ we);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_AES; i++) begin
        h0_q[i]  <= '0;
        h1_q[i]  <= '0;
        wa_q[i]  <= '0;
        wb_q[i]  <= '0;
        t0_q[i]  <= '0;
        t1_q[i]  <= '0;
        cid_q[i] <= '0;
        gid_q[i] <= '0;
      end
      xor_q       <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_label_q <= '0;
      out_cid_q   <= '0;
      out_gid_q   <= '0;
    end else begin
      h0_q[0]  <= aes_round(x0_in ^ aes_expanded_key_i[127:0], aes_expanded_key_i[255:128],
                            NR_AES == 1);
      h1_q[0]  <= aes_round(x1_in ^ aes_expanded_key_i[127:0], aes_expanded_key_i[255:128],
                            NR_AES == 1);
      wa_q[0]  <= in0_label_i;
      wb_q[0]  <= in1_label_i;
      t0_q[0]  <= t0_i;
      t1_q[0]  <= t1_i;
      cid_q[0] <= cid_i;
      gid_q[0] <= gid_i;
      for (int i = 1; i < NR_AES; i++) begin
        h0_q[i]  <= aes_round(h0_q[i-1], aes_expanded_key_i[128*(i+1) +: 128], i == NR_AES-1);
        h1_q[i]  <= aes_round(h1_q[i-1], aes_expanded_key_i[128*(i+1) +: 128], i == NR_AES-1);
        wa_q[i]  <= wa_q[i-1];
        wb_q[i]  <= wb_q[i-1];
        t0_q[i]  <= t0_q[i-1];
        t1_q[i]  <= t1_q[i-1];
        cid_q[i] <= cid_q[i-1];
        gid_q[i] <= gid_q[i-1];
      end
      xor_q       <= {xor_q[NR_AES-2:0], is_xor_i};
      vld_q       <= {vld_q[NR_AES-2:0], in_valid_i};
      out_valid_q <= vld_q[T];
      if (vld_q[T]) begin
        out_label_q <= out_label_d;
        out_cid_q   <= cid_q[T];
        out_gid_q   <= gid_q[T];
      end
    end
  end

`ifdef GC_EVAL_STATS_EN
  logic [31:0] gate_count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) gate_count_q <= '0;
    else if (vld_q[T]) gate_count_q <= gate_count_q + 32'd1;
  end

  assign gate_count_o = gate_count_q;
`endif

  assign out_valid_o = out_valid_q;
  assign out_label_o = out_label_q;
  assign out_cid_o   = out_cid_q;
  assign out_gid_o   = out_gid_q;
  assign busy_o      = in_valid_i | (|vld_q) | out_valid_q;

endmodule

// File: tb/tb_gc_eval_engine.sv
// Directed bench for gc_eval_engine: independent AES + half-gate garbler model produces expected labels.
module tb_gc_eval_engine;
  localparam int S = 20, K = 128, NR = 10, LAT = NR + 1;

  logic                  clk = 1'b0, rst = 1'b1;
  logic [128*(NR+1)-1:0] ek;
  logic                  in_valid, is_xor;
  logic [S-1:0]          cid, gid;
  logic [K-1:0]          wa, wb, t0, t1;
  logic                  out_valid, busy;
  logic [K-1:0]          out_label;
  logic [S-1:0]          out_cid, out_gid;
`ifdef GC_EVAL_STATS_EN
  logic [31:0]           gate_count;
`endif

  always #5 clk = ~clk;

  gc_eval_engine #(.S(S), .K(K), .NR_AES(NR)) dut (
    .clk_i(clk), .rst_i(rst), .aes_expanded_key_i(ek), .in_valid_i(in_valid), .is_xor_i(is_xor),
    .cid_i(cid), .gid_i(gid), .in0_label_i(wa), .in1_label_i(wb), .t0_i(t0), .t1_i(t1),
    .out_valid_o(out_valid), .out_label_o(out_label), .out_cid_o(out_cid), .out_gid_o(out_gid),
    .busy_o(busy)
`ifdef GC_EVAL_STATS_EN
    , .gate_count_o(gate_count)
`endif
  );

  typedef struct {
    logic         is_xor;
    logic [S-1:0] cid, gid;
    logic [K-1:0] wa, wb, t0, t1, exp;
  } vec_t;

  int           n_vec = 0, n_err = 0;
  logic [7:0]   sb [256];
  logic [127:0] rk [NR+1];
  vec_t         vecs [7];
  vec_t         strm [64];
  vec_t         gap [4];
  vec_t         g;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) begin
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      ek[128*r +: 128] = rk[r];
    end
  endtask

  function automatic logic [127:0] aes(input logic [127:0] x);
    logic [7:0]   st [4][4];
    logic [7:0]   tm [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = x[127-8*(4*c+r) -: 8] ^ rk[0][127-8*(4*c+r) -: 8];
    for (int n = 1; n <= NR; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) tm[r][c] = sb[st[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (n < NR) begin
          st[0][c] = gmul(8'h02, tm[0][c]) ^ gmul(8'h03, tm[1][c]) ^ tm[2][c] ^ tm[3][c];
          st[1][c] = tm[0][c] ^ gmul(8'h02, tm[1][c]) ^ gmul(8'h03, tm[2][c]) ^ tm[3][c];
          st[2][c] = tm[0][c] ^ tm[1][c] ^ gmul(8'h02, tm[2][c]) ^ gmul(8'h03, tm[3][c]);
          st[3][c] = gmul(8'h03, tm[0][c]) ^ tm[1][c] ^ tm[2][c] ^ gmul(8'h02, tm[3][c]);
        end else
          for (int r = 0; r < 4; r++) st[r][c] = tm[r][c];
        for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ rk[n][127-8*(4*c+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = st[r][c];
    return o;
  endfunction

  function automatic logic [127:0] hsh(input logic [127:0] x, input logic [S-1:0] c,
                                       input logic [S-1:0] gg, input logic lsb);
    logic [127:0] y;
    y = x ^ {{(K/2-S){1'b0}}, c, {(K/2-S-1){1'b0}}, gg, lsb};
    return y ^ aes(y);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Garbler side of a half-gate AND; evaluator input chosen by truth values a, b.
  task automatic make_and(input logic [S-1:0] c, input logic [S-1:0] gg, input logic a,
                          input logic b, output vec_t v);
    logic [127:0] r, a0, b0, tg, te, c0;
    r  = rnd128() | 128'h1;
    a0 = rnd128();
    b0 = rnd128();
    tg = hsh(a0, c, gg, 1'b0) ^ hsh(a0 ^ r, c, gg, 1'b0) ^ (b0[0] ? r : '0);
    te = hsh(b0, c, gg, 1'b1) ^ hsh(b0 ^ r, c, gg, 1'b1) ^ a0;
    c0 = hsh(a0, c, gg, 1'b0) ^ (a0[0] ? tg : '0) ^ hsh(b0, c, gg, 1'b1) ^ (b0[0] ? (te ^ a0) : '0);
    v.is_xor = 1'b0;
    v.cid = c;
    v.gid = gg;
    v.wa  = a ? a0 ^ r : a0;
    v.wb  = b ? b0 ^ r : b0;
    v.t0  = tg;
    v.t1  = te;
    v.exp = (a & b) ? c0 ^ r : c0;
  endtask

  task automatic make_xor(input logic [S-1:0] c, input logic [S-1:0] gg, input logic [127:0] x,
                          input logic [127:0] y, input logic [127:0] e, output vec_t v);
    v.is_xor = 1'b1;
    v.cid = c;
    v.gid = gg;
    v.wa  = x;
    v.wb  = y;
    v.t0  = rnd128();
    v.t1  = rnd128();
    v.exp = e;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    is_xor   = v.is_xor;
    cid      = v.cid;
    gid      = v.gid;
    wa       = v.wa;
    wb       = v.wb;
    t0       = v.t0;
    t1       = v.t1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    is_xor   = 1'($urandom());
    cid      = S'($urandom());
    gid      = S'($urandom());
    wa       = rnd128();
    wb       = rnd128();
    t0       = rnd128();
    t1       = rnd128();
  endtask

  initial begin
    logic exp_v, exp_b;
    build_sbox();
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    if (aes(128'h00112233445566778899aabbccddeeff) !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      $display("FAIL aes_model: reference model disagrees with known-answer vector");
      $fatal(1, "reference model broken");
    end
    idle();

    make_and(20'h00005, 20'h00007, 1'b0, 1'b0, vecs[0]);
    make_and(20'h00005, 20'h00007, 1'b0, 1'b1, vecs[1]);
    make_and(20'h00005, 20'h00007, 1'b1, 1'b0, vecs[2]);
    make_and(20'h00005, 20'h00007, 1'b1, 1'b1, vecs[3]);
    make_xor(20'h00001, 20'h00002, 128'h1, 128'h3, 128'h2, vecs[4]);
    make_xor(20'h00002, 20'h00003, 128'hff00, 128'h0ff0, 128'hf0f0, vecs[5]);
    make_and(20'hfffff, 20'hfffff, 1'b1, 1'b1, vecs[6]);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_label", out_label, 128'd0);
    chk("rst_out_cid", 128'(out_cid), 128'd0);
    chk("rst_out_gid", 128'(out_gid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single gates, one at a time: exact latency, result, then hold behaviour.
    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n]);
      for (int i = 1; i <= LAT + 1; i++) begin
        @(negedge clk);
        idle();
        #1;
        if (i == LAT - 1) chk($sformatf("vec%0d_early", n), 128'(out_valid), 128'd0);
        if (i == LAT) begin
          chk($sformatf("vec%0d_valid", n), 128'(out_valid), 128'd1);
          chk($sformatf("vec%0d_label", n), out_label, vecs[n].exp);
          chk($sformatf("vec%0d_ids", n), 128'({out_cid, out_gid}), 128'({vecs[n].cid, vecs[n].gid}));
        end
        if (i == LAT + 1) begin
          chk($sformatf("vec%0d_drop", n), 128'(out_valid), 128'd0);
          chk($sformatf("vec%0d_hold", n), out_label, vecs[n].exp);
        end
      end
    end

    // 64 gates back to back, mixed XOR/AND.
    for (int k = 0; k < 64; k++) begin
      if (k % 3 == 0) begin
        g.wa = rnd128();
        g.wb = rnd128();
        make_xor(S'(k + 100), S'(k), g.wa, g.wb, g.wa ^ g.wb, strm[k]);
      end else
        make_and(S'(k + 100), S'(k), 1'($urandom()), 1'($urandom()), strm[k]);
    end
    for (int m = 0; m < 64 + LAT + 1; m++) begin
      @(negedge clk);
      if (m < 64) drive(strm[m]);
      else idle();
      #1;
      exp_v = (m >= LAT) && (m - LAT < 64);
      chk($sformatf("strm_valid_m%0d", m), 128'(out_valid), 128'(exp_v));
      chk($sformatf("strm_busy_m%0d", m), 128'(busy), 128'(m < 64 + LAT));
      if (exp_v) begin
        chk($sformatf("strm_gid_m%0d", m), 128'(out_gid), 128'(strm[m-LAT].gid));
        chk($sformatf("strm_label_m%0d", m), out_label, strm[m-LAT].exp);
      end
    end

    // Gaps: valid pattern 1,0,0,1.
    make_and(20'h00042, 20'h00010, 1'b1, 1'b0, gap[0]);
    make_xor(20'h00042, 20'h00013, 128'h1234, 128'h00ff, 128'h12cb, gap[3]);
    for (int m = 0; m < 17; m++) begin
      @(negedge clk);
      if (m == 0 || m == 3) drive(gap[m]);
      else idle();
      #1;
      exp_v = (m == LAT) || (m == LAT + 3);
      exp_b = (m <= LAT + 3);
      chk($sformatf("gap_valid_m%0d", m), 128'(out_valid), 128'(exp_v));
      chk($sformatf("gap_busy_m%0d", m), 128'(busy), 128'(exp_b));
      if (exp_v) chk($sformatf("gap_label_m%0d", m), out_label, gap[m-LAT].exp);
    end

    // Reset mid-stream: five gates in flight are dropped; a gate presented at deassertion is kept.
    make_xor(20'h00003, 20'h00009, 128'h5, 128'h6, 128'h3, g);
    for (int m = 0; m < 26; m++) begin
      @(negedge clk);
      if (m < 5) drive(strm[m + 1]);
      else if (m == 9) begin
        rst = 1'b0;
        drive(g);
      end else idle();
      if (m == 7) rst = 1'b1;
      #1;
      if (m == 7) begin
        chk("midrst_label", out_label, 128'd0);
        chk("midrst_ids", 128'({out_cid, out_gid}), 128'd0);
      end
      exp_v = (m == 9 + LAT);
      if (m >= 7) begin
        chk($sformatf("midrst_valid_m%0d", m), 128'(out_valid), 128'(exp_v));
        chk($sformatf("midrst_busy_m%0d", m), 128'(busy), 128'(m >= 9 && m <= 9 + LAT));
      end
      if (exp_v) begin
        chk("midrst_first_label", out_label, g.exp);
        chk("midrst_first_gid", 128'(out_gid), 128'(g.gid));
      end
    end

`ifdef GC_EVAL_STATS_EN
    @(negedge clk);
    force dut.gate_count_q = 32'hffff_fffe;
    @(negedge clk);
    release dut.gate_count_q;
    for (int m = 0; m < 15; m++) begin
      @(negedge clk);
      if (m < 3) drive(vecs[4]);
      else idle();
      #1;
      if (m == LAT)     chk("cnt_max", 128'(gate_count), 128'(32'hffff_ffff));
      if (m == LAT + 1) chk("cnt_wrap", 128'(gate_count), 128'd0);
      if (m == LAT + 2) chk("cnt_one", 128'(gate_count), 128'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
